// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU (source 0) and MEM (source 1) results queue in per-source FIFOs and are
// granted round-robin into a registered regfile write port. Define WB_HAZARD_EN for the q_ra/q_hit lookup.
module wb_arbiter #(
    parameter int DATAWIDTH  = 32,
    parameter int REGISTERS  = 32,
    parameter int INDEX      = $clog2(REGISTERS),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [INDEX-1:0]     alu_wa,
    input  logic [DATAWIDTH-1:0] alu_wd,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [INDEX-1:0]     mem_wa,
    input  logic [DATAWIDTH-1:0] mem_wd,
    output logic                 werf,
    output logic [INDEX-1:0]     wa,
    output logic [DATAWIDTH-1:0] wd,
`ifdef WB_HAZARD_EN
    input  logic [INDEX-1:0]     q_ra,
    output logic                 q_hit,
`endif
    output logic                 busy
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [1:0]           in_valid;
    logic [1:0]           ready_vec;
    logic [1:0]           nonempty;
    logic [1:0]           grant;
    logic [INDEX-1:0]     in_wa   [2];
    logic [DATAWIDTH-1:0] in_wd   [2];
    logic [INDEX-1:0]     head_wa [2];
    logic [DATAWIDTH-1:0] head_wd [2];
`ifdef WB_HAZARD_EN
    logic [1:0]           fifo_hit;
`endif

    logic                 last_grant_reg;  // 1 = MEM was granted last
    logic                 werf_reg;
    logic [INDEX-1:0]     wa_reg;
    logic [DATAWIDTH-1:0] wd_reg;

    assign in_valid = {mem_valid, alu_valid};
    assign in_wa[0] = alu_wa;
    assign in_wa[1] = mem_wa;
    assign in_wd[0] = alu_wd;
    assign in_wd[1] = mem_wd;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic [PW:0]          wr_ptr_reg;
            logic [PW:0]          rd_ptr_reg;
            logic [INDEX-1:0]     wa_mem [FIFO_DEPTH];
            logic [DATAWIDTH-1:0] wd_mem [FIFO_DEPTH];
            logic                 full;
            logic                 push;

            // Extra wrap bit distinguishes full from empty when the index bits match.
            assign full = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                          (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
            assign nonempty[gi]  = (wr_ptr_reg != rd_ptr_reg);
            assign ready_vec[gi] = !full;
            // Writes to x0 finish the handshake but are never queued.
            assign push          = in_valid[gi] && !full && (in_wa[gi] != '0);
            assign head_wa[gi]   = wa_mem[rd_ptr_reg[PW-1:0]];
            assign head_wd[gi]   = wd_mem[rd_ptr_reg[PW-1:0]];

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push)
                        wr_ptr_reg <= wr_ptr_reg + {{PW{1'b0}}, 1'b1};
                    if (grant[gi])
                        rd_ptr_reg <= rd_ptr_reg + {{PW{1'b0}}, 1'b1};
                end
            end

            always_ff @(posedge clk) begin
                if (push) begin
                    wa_mem[wr_ptr_reg[PW-1:0]] <= in_wa[gi];
                    wd_mem[wr_ptr_reg[PW-1:0]] <= in_wd[gi];
                end
            end

`ifdef WB_HAZARD_EN
            logic [PW:0] count;
            logic        hit;

            assign count = wr_ptr_reg - rd_ptr_reg;

            // A slot is live when its distance from the read pointer is below the occupancy.
            always_comb begin
                hit = 1'b0;
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if (({1'b0, PW'(i) - rd_ptr_reg[PW-1:0]} < count) && (wa_mem[i] == q_ra))
                        hit = 1'b1;
                end
            end

            assign fifo_hit[gi] = hit;
`endif
        end
    endgenerate

    always_comb begin
        grant = nonempty;
        if (&nonempty)
            grant = last_grant_reg ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
            werf_reg       <= 1'b0;
            wa_reg         <= '0;
            wd_reg         <= '0;
        end else begin
            werf_reg <= |grant;
            if (|grant) begin
                last_grant_reg <= grant[1];
                wa_reg         <= grant[1] ? head_wa[1] : head_wa[0];
                wd_reg         <= grant[1] ? head_wd[1] : head_wd[0];
            end
        end
    end

    assign alu_ready = ready_vec[0];
    assign mem_ready = ready_vec[1];
    assign werf      = werf_reg;
    assign wa        = wa_reg;
    assign wd        = wd_reg;
    assign busy      = (|nonempty) | werf_reg;

`ifdef WB_HAZARD_EN
    assign q_hit = (q_ra != '0) && ((|fifo_hit) || (werf_reg && (wa_reg == q_ra)));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: per-source expected queues filled on handshake,
// drained and compared against the regfile write port every cycle.
module tb_wb_arbiter;

    localparam int DW    = 32;
    localparam int IW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [IW-1:0] wa;
        logic [DW-1:0] wd;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          alu_valid;
    logic          alu_ready;
    logic [IW-1:0] alu_wa;
    logic [DW-1:0] alu_wd;
    logic          mem_valid;
    logic          mem_ready;
    logic [IW-1:0] mem_wa;
    logic [DW-1:0] mem_wd;
    logic          werf;
    logic [IW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;
`ifdef WB_HAZARD_EN
    logic [IW-1:0] q_ra;
    logic          q_hit;
`endif

    int checks_total;
    int checks_passed;

    ent_t          alu_q[$];
    ent_t          mem_q[$];
    logic [IW-1:0] wr_log[$];
    ent_t          pend_a;
    ent_t          pend_m;
    ent_t          e;
    logic          pend_alu;
    logic          pend_mem;
    logic          rst_pend;
    logic          last_mem;
    int            sel;
    logic          exp_werf;
    logic [IW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    logic          exp_busy;
    logic          exp_hit;
    logic          a_rdy;
    logic          m_rdy;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .werf      (werf),
        .wa        (wa),
        .wd        (wd),
`ifdef WB_HAZARD_EN
        .q_ra      (q_ra),
        .q_hit     (q_hit),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks_total++;
        if (actual === expected)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    task automatic step();
        @(negedge clk);
        a_rdy = alu_ready;
        m_rdy = mem_ready;
        @(posedge clk);
        #1;
    endtask

    // Reference model: advances at each negedge using what was presented at the preceding posedge.
    initial begin
        rst_pend = 1'b1;
        sel      = 0;
        pend_alu = 1'b0;
        pend_mem = 1'b0;
        last_mem = 1'b1;
        exp_werf = 1'b0;
        exp_wa   = '0;
        exp_wd   = '0;
        forever begin
            @(negedge clk);
            if (rst_pend) begin
                alu_q.delete();
                mem_q.delete();
                sel      = 0;
                last_mem = 1'b1;
                exp_werf = 1'b0;
                exp_wa   = '0;
                exp_wd   = '0;
            end else begin
                exp_werf = 1'b0;
                if (sel == 1) begin
                    e = alu_q.pop_front();
                    exp_werf = 1'b1; exp_wa = e.wa; exp_wd = e.wd;
                end else if (sel == 2) begin
                    e = mem_q.pop_front();
                    exp_werf = 1'b1; exp_wa = e.wa; exp_wd = e.wd;
                end
                if (pend_alu) alu_q.push_back(pend_a);
                if (pend_mem) mem_q.push_back(pend_m);
            end
            if (werf) begin
                wr_log.push_back(wa);
                $display("write wa=%0d wd=0x%08h", wa, wd);
            end
            exp_busy = exp_werf || (alu_q.size() > 0) || (mem_q.size() > 0);
            check("werf", 64'(werf), 64'(exp_werf));
            check("wa", 64'(wa), 64'(exp_wa));
            check("wd", 64'(wd), 64'(exp_wd));
            check("alu_ready", 64'(alu_ready), 64'(alu_q.size() < DEPTH));
            check("mem_ready", 64'(mem_ready), 64'(mem_q.size() < DEPTH));
            check("busy", 64'(busy), 64'(exp_busy));
`ifdef WB_HAZARD_EN
            exp_hit = 1'b0;
            if (q_ra != '0) begin
                if (exp_werf && exp_wa == q_ra) exp_hit = 1'b1;
                foreach (alu_q[i]) if (alu_q[i].wa == q_ra) exp_hit = 1'b1;
                foreach (mem_q[i]) if (mem_q[i].wa == q_ra) exp_hit = 1'b1;
            end
            check("q_hit", 64'(q_hit), 64'(exp_hit));
`endif
            sel = 0;
            if (alu_q.size() > 0 && mem_q.size() > 0) sel = last_mem ? 1 : 2;
            else if (alu_q.size() > 0) sel = 1;
            else if (mem_q.size() > 0) sel = 2;
            if (sel != 0) last_mem = (sel == 2);
            pend_alu = !rst && alu_valid && (alu_q.size() < DEPTH) && (alu_wa != '0);
            pend_mem = !rst && mem_valid && (mem_q.size() < DEPTH) && (mem_wa != '0);
            pend_a   = '{wa: alu_wa, wd: alu_wd};
            pend_m   = '{wa: mem_wa, wd: mem_wd};
            rst_pend = rst;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int ai;
        int mi;
        int c;
        logic [IW-1:0] exp_order[$];
        checks_total  = 0;
        checks_passed = 0;
        rst = 1'b1;
        alu_valid = 1'b0; alu_wa = '0; alu_wd = '0;
        mem_valid = 1'b0; mem_wa = '0; mem_wd = '0;
`ifdef WB_HAZARD_EN
        q_ra = '0;
`endif
        step(); step();
        rst = 1'b0;
        step();

        // Single ALU write
        alu_valid = 1'b1; alu_wa = 5'd5; alu_wd = 32'hDEADBEEF;
        step();
        alu_valid = 1'b0;
        repeat (4) step();

        // Write to x0 is swallowed
        alu_valid = 1'b1; alu_wa = 5'd0; alu_wd = 32'h1234;
        step();
        check("x0_handshake_ready", 64'(a_rdy), 64'(1));
        alu_valid = 1'b0;
        repeat (3) step();

        // Both sources saturated
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_log.delete();
        ai = 0; mi = 0; c = 0;
        while ((ai < 8 || mi < 8) && c < 60) begin
            alu_valid = (ai < 8); alu_wa = IW'(ai + 1); alu_wd = 32'hA000_0000 + 32'(ai);
            mem_valid = (mi < 8); mem_wa = IW'(mi + 9); mem_wd = 32'hB000_0000 + 32'(mi);
            step();
            if (alu_valid && a_rdy) ai++;
            if (mem_valid && m_rdy) mi++;
            c++;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        check("t2_alu_accepted", 64'(ai), 64'(8));
        check("t2_mem_accepted", 64'(mi), 64'(8));
        repeat (20) step();
        for (int j = 0; j < 8; j++) begin
            exp_order.push_back(IW'(j + 1));
            exp_order.push_back(IW'(j + 9));
        end
        check("t2_write_count", 64'(wr_log.size()), 64'(16));
        for (int j = 0; j < 16 && j < wr_log.size(); j++)
            check("t2_order", 64'(wr_log[j]), 64'(exp_order[j]));

        // MEM-only burst drains in order
        mi = 0; c = 0;
        while (mi < 6 && c < 30) begin
            mem_valid = 1'b1; mem_wa = IW'(20 + mi); mem_wd = 32'hC000_0000 + 32'(mi);
            step();
            if (m_rdy) mi++;
            c++;
        end
        mem_valid = 1'b0;
        check("t4_mem_accepted", 64'(mi), 64'(6));
        repeat (8) step();

        // Reset with entries pending
        for (int j = 0; j < 3; j++) begin
            alu_valid = 1'b1; alu_wa = IW'(3 + j); alu_wd = 32'hD000_0000 + 32'(j);
            mem_valid = 1'b1; mem_wa = IW'(11 + j); mem_wd = 32'hE000_0000 + 32'(j);
            step();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (6) step();

`ifdef WB_HAZARD_EN
        q_ra = 5'd7;
        mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 32'h7777_0000;
        step();
        mem_valid = 1'b0;
        repeat (5) step();
        q_ra = 5'd0;
        mem_valid = 1'b1; mem_wa = 5'd7; mem_wd = 32'h7777_0001;
        step();
        mem_valid = 1'b0;
        repeat (5) step();
`endif

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
